rs_err_inject_ctrl: RTL and testbench

//   Frame sequencer and error-injection controller between the RS encoder output and the decoder input.
//   - On a start request, streams one codeword of N_SYM symbols from data_in to data_out.
//   - XORs programmable error patterns onto programmed symbol positions.
//   - Issues the decoder start pulse, flags corrupted symbols and counts injected errors and frames.
//   - A register-programmed error table replaces hard-coded error schedules.

---
 rtl/rs_err_inject_ctrl.sv | 102 ++++++++++
 tb/tb_rs_err_inject_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rs_err_inject_ctrl.sv
// rs_err_inject_ctrl: streams one RS codeword per start edge and XORs table-programmed errors onto chosen symbols
module rs_err_inject_ctrl #(
    parameter int SYM_W   = 4,
    parameter int N_SYM   = 15,
    parameter int MAX_ERR = 2,
    parameter int POS_W   = 4,
    parameter int FCNT_W  = 16,
    parameter int ADDR_W  = (MAX_ERR > 1) ? $clog2(MAX_ERR) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_req,
    input  logic [SYM_W-1:0]         data_in,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [POS_W+SYM_W:0]     cfg_wdata,
    output logic [SYM_W-1:0]         data_out,
    output logic                     sym_valid,
    output logic                     dec_start,
    output logic                     err,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     cfg_err,
    output logic [POS_W:0]           err_count,
    output logic [FCNT_W-1:0]        frame_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic start_req_q, start_rise, run, last, wr_ok;
    logic [POS_W-1:0] sym_idx;
    logic [SYM_W-1:0] mask;
    logic             tbl_en  [MAX_ERR];
    logic [POS_W-1:0] tbl_pos [MAX_ERR];
    logic [SYM_W-1:0] tbl_pat [MAX_ERR];
    assign start_rise = start_req & ~start_req_q;
    assign last       = sym_idx == POS_W'(N_SYM - 1);
    assign wr_ok      = cfg_we && state == IDLE && 32'(cfg_addr) < MAX_ERR;
    // state register and start-edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_req_q <= 1'b0;
        end else begin
            state       <= state_nx;
            start_req_q <= start_req;
        end
    end
    // next state: starts are only honoured in IDLE, DONE lasts one cycle
    always_comb begin
        state_nx = state == IDLE ? (start_rise ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    // state-derived controls
    always_comb begin
        busy = state != IDLE;
        run  = state == RUN;
    end
    // error mask for the current symbol; out-of-range positions never match sym_idx
    always_comb begin
        mask = '0;
        for (int e = 0; e < MAX_ERR; e++)
            if (tbl_en[e] && tbl_pos[e] == sym_idx) mask ^= tbl_pat[e];
    end
    // error table, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < MAX_ERR; e++) begin
                tbl_en[e]  <= 1'b0;
                tbl_pos[e] <= '0;
                tbl_pat[e] <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            for (int e = 0; e < MAX_ERR; e++)
                if (wr_ok && 32'(cfg_addr) == e) {tbl_en[e], tbl_pos[e], tbl_pat[e]} <= cfg_wdata;
            cfg_err <= cfg_we & ~wr_ok;
        end
    end
    // registered symbol path, frame markers and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            sym_valid  <= 1'b0;
            err        <= 1'b0;
            dec_start  <= 1'b0;
            frame_done <= 1'b0;
            sym_idx    <= '0;
            err_count  <= '0;
            frame_cnt  <= '0;
        end else begin
            data_out   <= run ? data_in ^ mask : '0;
            sym_valid  <= run;
            err        <= run && mask != '0;
            dec_start  <= run && sym_idx == '0;
            frame_done <= run && last;
            sym_idx    <= run ? sym_idx + 1'b1 : '0;
            if (state == IDLE && start_rise) err_count <= '0;
            else if (run && mask != '0) err_count <= err_count + 1'b1;
            if (state == DONE) frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rs_err_inject_ctrl.sv
// tb_rs_err_inject_ctrl: scoreboard bench with a per-frame corruption model
module tb_rs_err_inject_ctrl;
    localparam int N = 15;
    logic clk = 0, rst_n = 0, start_req = 0, cfg_we = 0;
    logic [3:0] data_in = '0;
    logic [0:0] cfg_addr = '0;
    logic [8:0] cfg_wdata = '0;
    logic [3:0] data_out;
    logic sym_valid, dec_start, err, frame_done, busy, cfg_err;
    logic [4:0] err_count;
    logic [15:0] frame_cnt;
    typedef struct {logic [3:0] d; logic e, ds, fd;} exp_t;
    exp_t q[$];
    exp_t x;
    logic [3:0] din [N];
    bit m_en [2];
    int m_pos [2], m_pat [2], m_fcnt;
    int n_chk, n_pass;
    rs_err_inject_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_req(start_req), .data_in(data_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .data_out(data_out), .sym_valid(sym_valid), .dec_start(dec_start), .err(err),
        .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err),
        .err_count(err_count), .frame_cnt(frame_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask
    // expected symbols of the next frame: scatter each enabled entry onto its position
    task automatic push_frame(input int nsym, output int nerr);
        int c [N];
        nerr = 0;
        foreach (c[k]) c[k] = 0;
        for (int e = 0; e < 2; e++)
            if (m_en[e] && m_pos[e] < N) c[m_pos[e]] ^= m_pat[e];
        for (int k = 0; k < nsym; k++) begin
            q.push_back('{d: 4'(din[k] ^ c[k]), e: c[k] != 0, ds: k == 0, fd: k == N - 1});
            if (c[k] != 0) nerr++;
        end
    endtask
    task automatic cfg_wr(input int addr, input bit en, input int pos, input int pat, input bit ok);
        @(negedge clk);
        cfg_we = 1; cfg_addr = 1'(addr); cfg_wdata = {en, 4'(pos), 4'(pat)};
        @(negedge clk);
        cfg_we = 0;
        chk("cfg_err", cfg_err, !ok);
        if (ok) begin m_en[addr] = en; m_pos[addr] = pos; m_pat[addr] = pat; end
    endtask
    task automatic run_frame(input bit wr, input int waddr, input bit wen, input int wpos, input int wpat);
        int nerr;
        @(negedge clk);
        start_req = 1;
        if (wr) begin
            cfg_we = 1; cfg_addr = 1'(waddr); cfg_wdata = {wen, 4'(wpos), 4'(wpat)};
            m_en[waddr] = wen; m_pos[waddr] = wpos; m_pat[waddr] = wpat;
        end
        push_frame(N, nerr);
        @(negedge clk);
        start_req = 0; cfg_we = 0; data_in = din[0];
        if (wr) chk("cfg_on_start", cfg_err, 0);
        for (int k = 1; k < N; k++) begin
            @(negedge clk);
            data_in = din[k];
        end
        repeat (3) @(negedge clk);
        m_fcnt++;
        chk("busy_after", busy, 0);
        chk("err_count", err_count, nerr);
        chk("frame_cnt", frame_cnt, m_fcnt & 16'hFFFF);
    endtask
    task automatic rand_din();
        foreach (din[k]) din[k] = 4'($urandom);
    endtask
    // monitor: every valid symbol must match the head of the scoreboard, idle cycles must be quiet
    always @(negedge clk) begin
        if (sym_valid) begin
            if (q.size() == 0) chk("unexpected_sym", 1, 0);
            else begin
                x = q.pop_front();
                chk("data_out", data_out, x.d);
                chk("err", err, x.e);
                chk("dec_start", dec_start, x.ds);
                chk("frame_done", frame_done, x.fd);
            end
        end else chk("idle_zero", {data_out, err, dec_start, frame_done}, 0);
    end
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        int nerr;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {data_out, sym_valid, dec_start, err, frame_done, busy, cfg_err}, 0);
        chk("rst_counts", {err_count, frame_cnt}, 0);
        rst_n = 1;
        foreach (din[k]) din[k] = 4'(k);
        run_frame(0, 0, 0, 0, 0);
        cfg_wr(0, 1, 1, 8, 1);
        cfg_wr(1, 1, 4, 8, 1);
        foreach (din[k]) din[k] = 4'h3;
        run_frame(0, 0, 0, 0, 0);
        cfg_wr(0, 1, 7, 5, 1);
        cfg_wr(1, 1, 7, 5, 1);
        rand_din();
        run_frame(0, 0, 0, 0, 0);
        cfg_wr(1, 1, 7, 'hA, 1);
        rand_din();
        run_frame(0, 0, 0, 0, 0);
        cfg_wr(0, 1, 2, 1, 1);
        cfg_wr(1, 0, 0, 0, 1);
        rand_din();
        fork
            run_frame(0, 0, 0, 0, 0);
            begin
                repeat (7) @(negedge clk);
                start_req = 1; cfg_we = 1; cfg_addr = 0; cfg_wdata = {1'b1, 4'd9, 4'hC};
                @(negedge clk);
                start_req = 0; cfg_we = 0;
                chk("cfg_busy", cfg_err, 1);
            end
        join
        rand_din();
        run_frame(0, 0, 0, 0, 0);
        cfg_wr(0, 1, 15, 'hF, 1);
        cfg_wr(1, 1, 3, 0, 1);
        rand_din();
        run_frame(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            for (int e = 0; e < 2; e++)
                if ($urandom_range(0, 1) == 1)
                    cfg_wr(e, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 15), $urandom_range(0, 15), 1);
            rand_din();
            if ($urandom_range(0, 2) == 0)
                run_frame(1, $urandom_range(0, 1), 1, $urandom_range(0, 14), $urandom_range(1, 15));
            else
                run_frame(0, 0, 0, 0, 0);
        end
        cfg_wr(0, 1, 10, 6, 1);
        rand_din();
        @(negedge clk);
        start_req = 1;
        push_frame(8, nerr);
        @(negedge clk);
        start_req = 0; data_in = din[0];
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            data_in = din[k];
        end
        #2 rst_n = 0;
        #1;
        chk("midrst_outputs", {data_out, sym_valid, dec_start, err, frame_done, busy, cfg_err}, 0);
        chk("midrst_counts", {err_count, frame_cnt}, 0);
        m_en[0] = 0; m_en[1] = 0; m_fcnt = 0;
        @(negedge clk);
        rst_n = 1;
        rand_din();
        run_frame(0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
